// File: rtl/dbg_trace_buf.sv
// Trace capture ring for the ZPU debug bus: records valid debug words while armed,
// optionally stops on a masked PC match plus a post-trigger count, then reads out oldest-first.
module dbg_trace_buf #(
  parameter int DBG_W = 137,
  parameter int PC_W  = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DBG_W-1:0] dbg_i,
  input  logic             arm,
  input  logic             stop,
  input  logic             mode,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [PC_W-1:0]  trig_mask,
  input  logic [AW-1:0]    post_len,
  input  logic             rd_en,
  output logic [DBG_W-2:0] rd_data,
  output logic             rd_valid,
  output logic [AW:0]      count,
  output logic [1:0]       state_o,
  output logic             ovf
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t              state, state_nxt;
  logic [DBG_W-2:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr, post_cnt, post_len_q;
  logic                mode_q;
  logic                cap_en, rd_ok;
  logic                rec_vld, trig_hit, trig_fire, wr_en, rd_fire;

  assign rec_vld   = dbg_i[DBG_W-1];
  assign trig_hit  = ((dbg_i[PC_W-1:0] ^ trig_pc) & trig_mask) == '0;
  assign trig_fire = (state == S_ARMED) && mode_q && rec_vld && trig_hit && !stop && !arm;
  // arm wins over everything that cycle, including a valid record or a pop
  assign wr_en     = cap_en && rec_vld && !arm;
  assign rd_fire   = rd_ok && rd_en && !arm && (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          if (stop)
            state_nxt = S_DONE;
          else if (mode_q && rec_vld && trig_hit)
            state_nxt = (post_len_q == '0) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (stop || (rec_vld && post_cnt == AW'(1)))
            state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_o = state;
    cap_en  = 1'b0;
    rd_ok   = 1'b0;
    case (state)
      S_ARMED, S_POST: cap_en = 1'b1;
      default:         rd_ok  = 1'b1;
    endcase
  end

  // Storage has no reset; count/pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dbg_i[DBG_W-2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      mode_q     <= 1'b0;
      post_len_q <= '0;
      post_cnt   <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      rd_valid   <= 1'b0;
      mode_q     <= mode;
      post_len_q <= post_len;
    end else begin
      rd_valid <= rd_fire;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        // full ring: drop the oldest entry instead of growing
        if (count == FULL) begin
          rd_ptr <= rd_ptr + 1'b1;
          ovf    <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        count   <= count - 1'b1;
      end
      if (trig_fire)
        post_cnt <= post_len_q;
      else if (state == S_POST && wr_en)
        post_cnt <= post_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_dbg_trace_buf.sv
// Self-checking bench for dbg_trace_buf: table-driven trigger run plus scoreboarded readout
// and hand-written corner sequences (overflow, priority, async reset).
module tb_dbg_trace_buf;

  localparam int DBG_W = 137;
  localparam int PC_W  = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [DBG_W-1:0] dbg_i;
  logic             arm, stop, mode, rd_en;
  logic [PC_W-1:0]  trig_pc, trig_mask;
  logic [AW-1:0]    post_len;
  logic [DBG_W-2:0] rd_data;
  logic             rd_valid, ovf;
  logic [AW:0]      count;
  logic [1:0]       state_o;

  int checks = 0;
  int errors = 0;
  logic [DBG_W-2:0] sb[$];
  logic [DBG_W-2:0] last_rd;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [1:0]  exp_state;
    logic [4:0]  exp_count;
  } vec_t;
  vec_t tbl[26];

  dbg_trace_buf #(.DBG_W(DBG_W), .PC_W(PC_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .dbg_i(dbg_i), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .trig_mask(trig_mask), .post_len(post_len), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .state_o(state_o), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [DBG_W-2:0] mk_rec(input logic [31:0] pc);
    mk_rec = {8'(pc ^ 32'h5A), pc ^ 32'hA5A5_0000, ~pc, pc + 32'h1234, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DBG_W-2:0] act, input logic [DBG_W-2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input logic [DBG_W-2:0] r);
    if (sb.size() == DEPTH) void'(sb.pop_front());
    sb.push_back(r);
  endtask

  task automatic feed(input logic vld, input logic [31:0] pc, input logic store);
    dbg_i = {vld, mk_rec(pc)};
    if (store) sb_push(mk_rec(pc));
    tick();
    dbg_i = '0;
  endtask

  task automatic do_arm(input logic m, input logic [31:0] tp, input logic [31:0] tm, input logic [AW-1:0] pl);
    mode = m; trig_pc = tp; trig_mask = tm; post_len = pl; arm = 1'b1;
    tick();
    arm = 1'b0;
    sb.delete();
    chk("arm_state", 136'(state_o), 136'd1);
    chk("arm_count", 136'(count), 136'd0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic drain(input int n);
    logic [DBG_W-2:0] e;
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("rd_valid", 136'(rd_valid), 136'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data", rd_data, e);
        last_rd = e;
      end else begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read %0d expected none left", i);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dbg_i = '0; arm = 0; stop = 0; mode = 0; rd_en = 0;
    trig_pc = '0; trig_mask = '0; post_len = '0; last_rd = '0;

    // trigger-run table: valid pcs 0xF0.. step 4, each followed by an invalid word carrying the trigger pc
    for (int i = 0; i < 13; i++) begin
      tbl[2*i].vld       = 1'b1;
      tbl[2*i].pc        = 32'hF0 + 32'(4*i);
      tbl[2*i].exp_count = (i < 8) ? 5'(i+1) : 5'd8;
      tbl[2*i].exp_state = (i < 4) ? 2'd1 : (i < 7) ? 2'd2 : 2'd3;
      tbl[2*i+1]         = tbl[2*i];
      tbl[2*i+1].vld     = 1'b0;
      tbl[2*i+1].pc      = 32'h100;
    end

    #12;
    chk("rst_state", 136'(state_o), 136'd0);
    chk("rst_count", 136'(count), 136'd0);
    chk("rst_rdv", 136'(rd_valid), 136'd0);
    chk("rst_ovf", 136'(ovf), 136'd0);
    chk("rst_rdata", rd_data, '0);
    rst = 1'b1;
    tick();

    // free run, 5 records
    do_arm(1'b0, 32'h0, 32'h0, 4'd0);
    for (int i = 0; i < 5; i++) feed(1'b1, 32'h10 + 32'(i), 1'b1);
    do_stop();
    chk("free_count", 136'(count), 136'd5);
    chk("free_ovf", 136'(ovf), 136'd0);
    chk("free_state", 136'(state_o), 136'd3);
    drain(5);
    chk("free_empty", 136'(count), 136'd0);

    // wrap/overflow
    do_arm(1'b0, 32'h0, 32'h0, 4'd0);
    for (int i = 0; i < 20; i++) feed(1'b1, 32'(i), 1'b1);
    do_stop();
    chk("wrap_count", 136'(count), 136'd16);
    chk("wrap_ovf", 136'(ovf), 136'd1);
    chk("wrap_first", sb[0], mk_rec(32'd4));
    drain(16);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("wrap_17_rdv", 136'(rd_valid), 136'd0);
    chk("wrap_17_hold", rd_data, mk_rec(32'd19));
    chk("wrap_17_count", 136'(count), 136'd0);

    // triggered run from the table
    do_arm(1'b1, 32'h100, 32'hFFFF_FFFF, 4'd3);
    foreach (tbl[i]) begin
      feed(tbl[i].vld, tbl[i].pc, tbl[i].vld && (tbl[i].exp_count > 5'(sb.size())));
      chk($sformatf("trig_state_%0d", i), 136'(state_o), 136'(tbl[i].exp_state));
      chk($sformatf("trig_count_%0d", i), 136'(count), 136'(tbl[i].exp_count));
    end
    drain(8);
    chk("trig_last", last_rd, mk_rec(32'h10C));

    // masked trigger, zero post length
    do_arm(1'b1, 32'h200, 32'hFFFF_FF00, 4'd0);
    feed(1'b1, 32'h1A0, 1'b1);
    chk("mask_nomatch", 136'(state_o), 136'd1);
    feed(1'b1, 32'h2A4, 1'b1);
    chk("mask_done", 136'(state_o), 136'd3);
    feed(1'b1, 32'h2A8, 1'b0);
    chk("mask_frozen", 136'(count), 136'd2);
    drain(2);
    chk("mask_last", last_rd, mk_rec(32'h2A4));

    // arm beats stop; reads ignored while armed
    do_arm(1'b0, 32'h0, 32'h0, 4'd0);
    feed(1'b1, 32'h55, 1'b1);
    feed(1'b1, 32'h56, 1'b1);
    arm = 1'b1; stop = 1'b1;
    tick();
    arm = 1'b0; stop = 1'b0;
    chk("prio_state", 136'(state_o), 136'd1);
    chk("prio_count", 136'(count), 136'd0);
    feed(1'b1, 32'h57, 1'b1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("armed_rd_rdv", 136'(rd_valid), 136'd0);
    chk("armed_rd_count", 136'(count), 136'd1);

    // async reset in the middle of POST
    do_arm(1'b1, 32'h300, 32'hFFFF_FFFF, 4'd5);
    feed(1'b1, 32'h300, 1'b1);
    feed(1'b1, 32'h304, 1'b1);
    chk("post_state", 136'(state_o), 136'd2);
    #2 rst = 1'b0;
    #1;
    chk("areset_state", 136'(state_o), 136'd0);
    chk("areset_count", 136'(count), 136'd0);
    chk("areset_rdv", 136'(rd_valid), 136'd0);
    #3 rst = 1'b1;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("idle_empty_rdv", 136'(rd_valid), 136'd0);
    chk("idle_state", 136'(state_o), 136'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_trace_buf.md
Name: dbg_trace_buf

Overview:
- Parametrised on-chip trace capture buffer for the pipelined ZPU debug bus.
- Records valid dbg_o words (pc/sp/tos/nos/inst + valid flag) into a ring of DEPTH entries.
- Supports free-running capture or PC-match trigger with a programmable post-trigger count; frozen contents are read out oldest-first.
- Sits beside zpu_core as a synthesizable successor to the simulation-only trace consumer.

Parameters:
- DBG_W, 137: debug word width. Bit DBG_W-1 is the valid flag; bits [DBG_W-2:0] are the record.
- PC_W, 32: PC field width, located at dbg_i[PC_W-1:0].
- DEPTH, 16: number of entries. Must be a power of two, >=2.
- AW, log2(DEPTH): pointer width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- dbg_i  in  DBG_W  debug word from core; record is valid when dbg_i[DBG_W-1]=1
- arm  in  1  one-cycle pulse: clear buffer and start capture
- stop  in  1  one-cycle pulse: end capture in free mode
- mode  in  1  0 = free-run, 1 = triggered; sampled on arm
- trig_pc  in  PC_W  trigger PC value
- trig_mask  in  PC_W  compare mask; 1 = bit compared
- post_len  in  AW  records to capture after the trigger record; sampled on arm
- rd_en  in  1  pop request
- rd_data  out  DBG_W-1  popped record
- rd_valid  out  1  rd_data valid, one-cycle pulse
- count  out  AW+1  entries held, 0..DEPTH
- state_o  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- ovf  out  1  sticky; oldest entry was overwritten since arm

Behaviour:
Reset (rst=0, asynchronous):
- State IDLE; pointers, count, rd_data, rd_valid and ovf all 0.

Capture:
- A write occurs only when dbg_i[DBG_W-1]=1 in state ARMED or POST.
- Data written is dbg_i[DBG_W-2:0] at wr_ptr; wr_ptr increments and wraps modulo DEPTH.
- While count<DEPTH, count increments on each write.
- If count==DEPTH, the write overwrites the oldest entry: rd_ptr advances, count holds, ovf is set.

State transitions:
- IDLE: arm -> ARMED. At the same edge, clear pointers, count and ovf, and latch mode and post_len.
- ARMED, triggered mode: a valid record with ((dbg_i[PC_W-1:0] ^ trig_pc) & trig_mask)==0 is written. The machine then goes to POST with post_cnt=post_len, or straight to DONE if post_len==0.
- ARMED, free mode: the trigger is ignored. stop -> DONE; a valid record in the same cycle is still written.
- ARMED, triggered mode: stop -> DONE; no trigger occurred.
- POST: each valid record is written and decrements post_cnt. The write that makes post_cnt reach 0 also moves to DONE. stop -> DONE.
- DONE: no writes. count, ovf and contents are frozen except for reads.
- Any state: arm restarts per the IDLE rule. arm beats a simultaneous stop, trigger or rd_en.

Readout:
- Permitted only in IDLE or DONE; rd_en is ignored in ARMED and POST.
- If count>0, rd_data <= mem[rd_ptr] at the next edge (1-cycle latency) and rd_valid=1 for one cycle. rd_ptr increments with wrap and count decrements.
- rd_en with count==0: no pop, rd_valid=0, rd_data holds.
- Back-to-back rd_en returns consecutive entries, one per cycle.

Arithmetic and edge cases:
- count is AW+1 bits and never exceeds DEPTH.
- post_len is limited by its width to DEPTH-1, so the trigger record is always retained.
- dbg_i with the valid bit at 0 is never stored and never advances post_cnt.
- Reset asserted mid-capture or mid-readout returns to IDLE immediately; contents are discarded (count=0).

Test Plan:
- Free-run, DEPTH=16: arm (mode=0), 5 valid records with pc=0x10..0x14, stop. Expect count=5, ovf=0, state=3. Five rd_en pulses return pc 0x10..0x14, then count=0.
- Wrap/overflow: arm free, 20 valid records with pc=0..19, stop. Expect count=16, ovf=1. Readout returns pc 4..19 in order; a 17th rd_en gives no rd_valid.
- Trigger: arm (mode=1, trig_pc=0x100, trig_mask=0xFFFFFFFF, post_len=3), feed pc 0xF0..0x120 step 4, interleaved with invalid cycles. Expect DONE after pc=0x10C. Last four entries read are 0x100, 0x104, 0x108, 0x10C. Invalid words are never stored.
- Masked, zero post: trig_pc=0x200, trig_mask=0xFFFFFF00, post_len=0. Record pc=0x2A4 moves to DONE in the same cycle; the last entry is pc 0x2A4.
- Priority: in ARMED, assert arm and stop together, expect ARMED with count=0. Then rd_en during ARMED, expect no rd_valid.
- Async reset: pull rst low mid-POST between clock edges. Expect state_o=0, count=0, rd_valid=0 immediately, without waiting for a clock edge.
